i3_operand_loader: RTL and testbench

Serial-to-parallel frame loader directly upstream of the i3 pairwise-OR/AND-reduce check stage. It assembles one 132-bit operand frame from a narrow valid/ready beat stream and holds it on six field buses (pv28, pv56, pv88, pv120, pv126, pv132) that drive the combinational check inputs unchanged. It then releases the frame through a valid/ready handshake. Framing errors are detected, the bad frame is discarded, and the errors are counted.

---
 rtl/i3_pkg.sv | 30 +++
 rtl/i3_operand_loader_if.sv | 52 +++++
 rtl/i3_sat_counter.sv | 30 +++
 rtl/i3_operand_loader.sv | 121 ++++++++++++
 tb/tb_i3_operand_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i3_pkg.sv
// Frame layout and loader state encoding shared by the i3 operand loader,
// the downstream check stage and their benches.
package i3_pkg;

    localparam int unsigned FRAME_W = 132;

    localparam int unsigned PV28_LO  = 0;
    localparam int unsigned PV28_W   = 28;
    localparam int unsigned PV56_LO  = 28;
    localparam int unsigned PV56_W   = 28;
    localparam int unsigned PV88_LO  = 56;
    localparam int unsigned PV88_W   = 32;
    localparam int unsigned PV120_LO = 88;
    localparam int unsigned PV120_W  = 32;
    localparam int unsigned PV126_LO = 120;
    localparam int unsigned PV126_W  = 6;
    localparam int unsigned PV132_LO = 126;
    localparam int unsigned PV132_W  = 6;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int unsigned nbeats(input int unsigned beat_w);
        return (FRAME_W + beat_w - 1) / beat_w;
    endfunction

endpackage

// File: rtl/i3_operand_loader_if.sv
// Beat stream in, held frame out: the loader uses the slave view, the
// upstream/downstream environment uses the master view.
interface i3_operand_loader_if
    import i3_pkg::*;
#(
    parameter int unsigned BEAT_W = 8
);

    logic                s_valid;
    logic                s_ready;
    logic [BEAT_W-1:0]   s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [PV28_W-1:0]   pv28;
    logic [PV56_W-1:0]   pv56;
    logic [PV88_W-1:0]   pv88;
    logic [PV120_W-1:0]  pv120;
    logic [PV126_W-1:0]  pv126;
    logic [PV132_W-1:0]  pv132;

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  m_ready,
        output s_ready,
        output m_valid,
        output pv28,
        output pv56,
        output pv88,
        output pv120,
        output pv126,
        output pv132
    );

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  pv28,
        input  pv56,
        input  pv88,
        input  pv120,
        input  pv126,
        input  pv132
    );

endinterface

// File: rtl/i3_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high reset.
module i3_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/i3_operand_loader.sv
// Assembles a 132-bit operand frame from LSB-first beats, holds it on the
// field buses until consumed, and drops/counts malformed frames.
module i3_operand_loader
    import i3_pkg::*;
#(
    parameter int unsigned BEAT_W = 8,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    i3_operand_loader_if.slave   bus,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 busy
);

    localparam int unsigned NBEATS = nbeats(BEAT_W);
    localparam int unsigned IDX_W  = $clog2(NBEATS);
    localparam int unsigned SH_W   = $clog2(FRAME_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 err_inc;
    logic                 s_ready;
    logic                 beat_fire;
    logic                 at_last_idx;
    logic [SH_W-1:0]      shamt;
    logic [FRAME_W-1:0]   data_ext;
    logic [FRAME_W-1:0]   mask_ext;
    logic [FRAME_W-1:0]   frame_wr;

    // Ready decodes only registered state; rst gates it so nothing is offered
    // while the block is being cleared.
    assign s_ready     = !rst && (state_q != HOLD);
    assign beat_fire   = bus.s_valid && s_ready;
    assign at_last_idx = (idx_q == LAST_IDX);

    // Shifting past FRAME_W drops the final beat's surplus payload bits.
    assign shamt    = SH_W'(idx_q * BEAT_W);
    assign data_ext = FRAME_W'(bus.s_data) << shamt;
    assign mask_ext = FRAME_W'({BEAT_W{1'b1}}) << shamt;
    assign frame_wr = (frame_q & ~mask_ext) | (data_ext & mask_ext);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        err_inc = 1'b0;

        unique case (state_q)
            FILL: begin
                if (beat_fire) begin
                    if (bus.s_last && at_last_idx) begin
                        frame_d = frame_wr;
                        idx_d   = '0;
                        state_d = HOLD;
                    end else if (bus.s_last) begin
                        idx_d   = '0;
                        err_inc = 1'b1;
                    end else if (at_last_idx) begin
                        idx_d   = '0;
                        err_inc = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        frame_d = frame_wr;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (beat_fire && bus.s_last) begin
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    state_d = FILL;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

    i3_sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (err_inc),
        .count_o (err_cnt)
    );

    assign bus.s_ready = s_ready;
    assign bus.m_valid = (state_q == HOLD);
    assign busy        = (state_q != FILL) || (idx_q != '0);

    assign bus.pv28  = frame_q[PV28_LO  +: PV28_W];
    assign bus.pv56  = frame_q[PV56_LO  +: PV56_W];
    assign bus.pv88  = frame_q[PV88_LO  +: PV88_W];
    assign bus.pv120 = frame_q[PV120_LO +: PV120_W];
    assign bus.pv126 = frame_q[PV126_LO +: PV126_W];
    assign bus.pv132 = frame_q[PV132_LO +: PV132_W];

endmodule

// File: tb/tb_i3_operand_loader.sv
// Randomised bench for i3_operand_loader against a beat-level frame model.
module tb_i3_operand_loader;
    import i3_pkg::*;

    localparam int unsigned BW      = 8;
    localparam int unsigned ERR_W   = 8;
    localparam int          NB      = (132 + BW - 1) / BW;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [ERR_W-1:0] err_cnt;
    logic             busy;
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;

    i3_operand_loader_if #(.BEAT_W(BW)) bus ();

    i3_operand_loader #(
        .BEAT_W (BW),
        .ERR_W  (ERR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: frames built from the stream rules alone.
    int                 m_cnt;
    bit                 m_drain;
    int                 m_errs;
    logic [131:0]       m_asm;
    logic [131:0]       exp_q[$];

    function automatic void model_reset();
        m_cnt   = 0;
        m_drain = 0;
        m_errs  = 0;
        exp_q.delete();
    endfunction

    function automatic void model_beat(input logic [BW-1:0] d, input logic l);
        if (m_drain) begin
            if (l) m_drain = 0;
            return;
        end
        m_cnt++;
        for (int i = 0; i < BW; i++) begin
            int p;
            p = (m_cnt - 1) * BW + i;
            if (p < 132) m_asm[p] = d[i];
        end
        if (l) begin
            if (m_cnt == NB) exp_q.push_back(m_asm);
            else m_errs++;
            m_cnt = 0;
        end else if (m_cnt == NB) begin
            m_errs++;
            m_drain = 1;
            m_cnt   = 0;
        end
    endfunction

    function automatic int exp_err();
        return (m_errs > ERR_MAX) ? ERR_MAX : m_errs;
    endfunction

    function automatic logic [131:0] frame_bus();
        return {bus.pv132, bus.pv126, bus.pv120, bus.pv88, bus.pv56, bus.pv28};
    endfunction

    // Every consumed frame must match the oldest completed model frame.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL frame_unexpected got=%h required=no frame", frame_bus());
            end else begin
                logic [131:0] e;
                e = exp_q.pop_front();
                if (frame_bus() !== e) begin
                    failures++;
                    $display("FAIL frame_data got=%h required=%h", frame_bus(), e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic l);
        int w;
        w = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (bus.s_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        if (bus.s_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout s_ready=%b required=1 within 50 cycles", bus.s_ready);
        end else begin
            step();
            model_beat(d, l);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic send_good_frame();
        for (int k = 0; k < NB; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                bus.s_data  = BW'($urandom);
                bus.s_last  = 1'b1;
                repeat ($urandom_range(1, 2)) step();
            end
            send_beat(BW'($urandom), k == NB - 1);
        end
    endtask

    task automatic chk_err(input string name);
        checks++;
        if (err_cnt !== ERR_W'(exp_err())) begin
            failures++;
            $display("FAIL %s err_cnt=%0d required=%0d", name, err_cnt, exp_err());
        end
    endtask

    task automatic chk_mvalid(input string name, input logic req);
        checks++;
        if (bus.m_valid !== req) begin
            failures++;
            $display("FAIL %s m_valid=%b required=%b", name, bus.m_valid, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        step();
        step();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl m_valid=%b s_ready=%b busy=%b required=0 0 0",
                     bus.m_valid, bus.s_ready, busy);
        end
        checks++;
        if (err_cnt !== '0 || frame_bus() !== '0) begin
            failures++;
            $display("FAIL reset_data err_cnt=%0d buses=%h required=0 0", err_cnt, frame_bus());
        end
        rst = 1'b0;
        model_reset();
        step();
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release s_ready=%b required=1", bus.s_ready);
        end
    endtask

    task automatic test_nominal();
        int c0;
        bus.m_ready = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 16; k++) send_beat(BW'(k), 1'b0);
        chk_mvalid("nominal_pre_last", 1'b0);
        send_beat(8'h0A, 1'b1);
        checks++;
        if (cyc - c0 != NB) begin
            failures++;
            $display("FAIL nominal_latency edges=%0d required=%0d", cyc - c0, NB);
        end
        chk_mvalid("nominal_mvalid", 1'b1);
        checks++;
        if (bus.pv28 !== 28'h3020100 || bus.pv132 !== 6'h28 || bus.pv126 !== 6'h0F) begin
            failures++;
            $display("FAIL nominal_fields pv28=%h pv132=%h pv126=%h required=3020100 28 0f",
                     bus.pv28, bus.pv132, bus.pv126);
        end
        checks++;
        if (exp_q.size() != 1 || frame_bus() !== exp_q[0]) begin
            failures++;
            $display("FAIL nominal_frame got=%h required=model frame (queued=%0d)",
                     frame_bus(), exp_q.size());
        end
        chk_err("nominal_err");
    endtask

    task automatic test_backpressure();
        logic [131:0] snap;
        snap = frame_bus();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (frame_bus() !== snap || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d s_ready=%b m_valid=%b stable=%b required=0 1 1",
                         i, bus.s_ready, bus.m_valid, frame_bus() === snap);
            end
        end
        bus.m_ready = 1'b1;
        step();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release m_valid=%b s_ready=%b required=0 1",
                     bus.m_valid, bus.s_ready);
        end
    endtask

    task automatic test_early_last();
        bus.m_ready = 1'b1;
        for (int k = 0; k < 6; k++) send_beat(BW'($urandom), k == 5);
        chk_err("early_last_err");
        chk_mvalid("early_last_no_frame", 1'b0);
        send_good_frame();
        chk_mvalid("early_last_good_frame", 1'b1);
        step();
    endtask

    task automatic test_missing_last();
        bus.m_ready = 1'b1;
        for (int k = 0; k < NB; k++) send_beat(BW'($urandom), 1'b0);
        chk_err("missing_last_err");
        checks++;
        if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL missing_last_drain busy=%b s_ready=%b required=1 1", busy, bus.s_ready);
        end
        send_beat(BW'($urandom), 1'b0);
        send_beat(BW'($urandom), 1'b0);
        chk_mvalid("missing_last_drain_no_frame", 1'b0);
        send_beat(BW'($urandom), 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL missing_last_exit busy=%b required=0", busy);
        end
        chk_err("missing_last_err_after_drain");
        send_good_frame();
        chk_mvalid("missing_last_good_frame", 1'b1);
        step();
    endtask

    task automatic test_random_mix();
        bus.m_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                send_good_frame();
            end else if (kind == 1) begin
                n = $urandom_range(1, NB - 1);
                for (int k = 0; k < n; k++) send_beat(BW'($urandom), k == n - 1);
            end else begin
                for (int k = 0; k < NB; k++) send_beat(BW'($urandom), 1'b0);
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) send_beat(BW'($urandom), k == n - 1);
            end
            chk_err("random_err");
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_undelivered pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        step();
        for (int i = 0; i < 300; i++) send_beat(BW'($urandom), 1'b1);
        chk_err("saturation_err");
        checks++;
        if (err_cnt !== ERR_W'(ERR_MAX)) begin
            failures++;
            $display("FAIL saturation_value err_cnt=%0d required=%0d", err_cnt, ERR_MAX);
        end
    endtask

    task automatic test_reset_mid();
        bus.m_ready = 1'b1;
        for (int k = 0; k < 9; k++) send_beat(BW'($urandom), 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_busy busy=%b required=1", busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0 || busy !== 1'b0 ||
            err_cnt !== '0 || frame_bus() !== '0) begin
            failures++;
            $display("FAIL mid_frame_reset m_valid=%b s_ready=%b busy=%b err=%0d buses=%h required=0 0 0 0 0",
                     bus.m_valid, bus.s_ready, busy, err_cnt, frame_bus());
        end
        rst = 1'b0;
        model_reset();
        step();
        bus.m_ready = 1'b0;
        send_good_frame();
        chk_mvalid("hold_before_reset", 1'b1);
        rst = 1'b1;
        step();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0 || frame_bus() !== '0) begin
            failures++;
            $display("FAIL hold_reset m_valid=%b s_ready=%b buses=%h required=0 0 0",
                     bus.m_valid, bus.s_ready, frame_bus());
        end
        rst = 1'b0;
        model_reset();
        step();
        bus.m_ready = 1'b1;
        send_good_frame();
        chk_mvalid("post_reset_frame", 1'b1);
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_undelivered pending=%0d required=0", exp_q.size());
        end
        chk_err("post_reset_err");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_random_mix();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
